// File: rtl/spi_ssram_bridge_if.sv
// Bus between the SPI bridge and the row/column-decoded register array.
// The shared data bus is resolved here from the bridge (write) and array (read) drivers.
interface spi_ssram_bridge_if #(
    parameter int WIDTH = 16
);
    logic             sck;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    logic [15:0]      row;
    logic [15:0]      column;
    logic             we;
    logic             re;
    logic             busy;
    logic             frame_err;
    wire  [WIDTH-1:0] data;

    // Bridge-side and array-side drivers of the shared data bus
    logic [WIDTH-1:0] data_out;
    logic             data_oe;
    logic [WIDTH-1:0] ext_data;
    logic             ext_oe;

    assign data = data_oe ? data_out : {WIDTH{1'bz}};
    assign data = ext_oe  ? ext_data : {WIDTH{1'bz}};

    modport slave (
        input  sck, cs_n, mosi, data,
        output miso, row, column, we, re, busy, frame_err, data_out, data_oe
    );

    modport master (
        output sck, cs_n, mosi, ext_data, ext_oe,
        input  miso, row, column, we, re, busy, frame_err, data
    );
endinterface

// File: rtl/spi_ssram_bridge.sv
// SPI mode-0 slave that turns command/address/data frames into one-hot row/column
// strobes for a 256-entry register file, with auto-increment read and write bursts.
module spi_ssram_bridge #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    spi_ssram_bridge_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, RD_STROBE, RD_SHIFT, WR_DATA, WR_STROBE
    } state_t;

    localparam logic [5:0] WLAST = 6'(WIDTH - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q;
    logic [5:0]             cnt_q, cnt_d;
    logic [6:0]             byte_q, byte_d;
    logic                   rd_q, rd_d;
    logic [7:0]             addr_q, addr_d;
    logic [WIDTH-1:0]       word_q, word_d;
    logic                   miso_q, miso_d;
    logic                   err_q, err_d;
    logic                   busy_q;

    logic sck_s, cs_s, mosi_s, rise, fall, strobe;
    logic [15:0] row_w, col_w;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign rise   = sck_s & ~sck_prev_q;
    assign fall   = ~sck_s & sck_prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cnt_q       <= '0;
            byte_q      <= '0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            word_q      <= '0;
            miso_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sck_prev_q  <= sck_s;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            miso_q      <= miso_d;
            err_q       <= err_d;
            busy_q      <= ~cs_s;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        word_d  = word_q;
        miso_d  = miso_q;
        err_d   = 1'b0;
        // Deselect wins over everything; a nonzero bit count means a partial byte/word
        if (state_q != IDLE && cs_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
            err_d   = (cnt_q != 6'd0);
        end else begin
            case (state_q)
                IDLE: begin
                    miso_d = 1'b0;
                    cnt_d  = '0;
                    if (!cs_s) state_d = CMD;
                end
                CMD: if (rise) begin
                    byte_d = {byte_q[5:0], mosi_s};
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd7) begin
                        rd_d    = mosi_s;
                        cnt_d   = '0;
                        state_d = ADDR;
                    end
                end
                ADDR: if (rise) begin
                    byte_d = {byte_q[5:0], mosi_s};
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd7) begin
                        addr_d  = {byte_q, mosi_s};
                        cnt_d   = '0;
                        state_d = rd_q ? RD_STROBE : WR_DATA;
                    end
                end
                RD_STROBE: begin
                    word_d  = bus.data;
                    miso_d  = bus.data[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RD_SHIFT;
                end
                RD_SHIFT: begin
                    // cnt_q==0 marks the fall right after a reload, which must not shift
                    if (rise) begin
                        if (cnt_q == WLAST) begin
                            addr_d  = addr_q + 8'd1;
                            cnt_d   = '0;
                            state_d = RD_STROBE;
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                    end else if (fall && cnt_q != 6'd0) begin
                        word_d = word_q << 1;
                        miso_d = word_d[WIDTH-1];
                    end
                end
                WR_DATA: if (rise) begin
                    word_d = (word_q << 1) | WIDTH'(mosi_s);
                    if (cnt_q == WLAST) begin
                        cnt_d   = '0;
                        state_d = WR_STROBE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                WR_STROBE: begin
                    addr_d  = addr_q + 8'd1;
                    cnt_d   = '0;
                    state_d = WR_DATA;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign strobe = (state_q == RD_STROBE) || (state_q == WR_STROBE);

    for (genvar gi = 0; gi < 16; gi++) begin : g_dec
        assign row_w[gi] = strobe && (addr_q[7:4] == 4'(gi));
        assign col_w[gi] = strobe && (addr_q[3:0] == 4'(gi));
    end

    assign bus.row       = row_w;
    assign bus.column    = col_w;
    assign bus.we        = (state_q == WR_STROBE);
    assign bus.re        = (state_q == RD_STROBE);
    assign bus.data_out  = word_q;
    assign bus.data_oe   = (state_q == WR_STROBE);
    assign bus.miso      = miso_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_spi_ssram_bridge.sv
// Directed bench: a host drives SPI frames while a small register-array model answers reads
// and records every strobe.
module tb_spi_ssram_bridge;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spi_ssram_bridge_if #(.WIDTH(16)) bus();

    spi_ssram_bridge #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [15:0] mem [256];
    logic [15:0] we_row[$], we_col[$], we_dat[$];
    logic [15:0] re_row[$], re_col[$];
    int          err_n   = 0;
    int          overlap = 0;

    function automatic logic [7:0] idx_of(input logic [15:0] r, input logic [15:0] c);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (r[i]) v[7:4] = 4'(i);
            if (c[i]) v[3:0] = 4'(i);
        end
        return v;
    endfunction

    assign bus.ext_oe   = bus.re;
    assign bus.ext_data = mem[idx_of(bus.row, bus.column)];

    always @(negedge clk) begin
        if (bus.we) begin
            we_row.push_back(bus.row);
            we_col.push_back(bus.column);
            we_dat.push_back(bus.data);
            mem[idx_of(bus.row, bus.column)] <= bus.data;
            $display("we  addr=%h data=%h", idx_of(bus.row, bus.column), bus.data);
        end
        if (bus.re) begin
            re_row.push_back(bus.row);
            re_col.push_back(bus.column);
            $display("re  addr=%h data=%h", idx_of(bus.row, bus.column), bus.data);
        end
        if (bus.frame_err) err_n <= err_n + 1;
        if (bus.we && bus.re) overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        bus.mosi = b;
        repeat (8) @(negedge clk);
        m = bus.miso;
        bus.sck = 1'b1;
        repeat (8) @(negedge clk);
        bus.sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v);
        logic m;
        for (int i = 7; i >= 0; i--) spi_bit(v[i], m);
    endtask

    task automatic spi_wr_word(input logic [15:0] v);
        logic m;
        for (int i = 15; i >= 0; i--) spi_bit(v[i], m);
    endtask

    task automatic spi_rd_word(output logic [15:0] v);
        logic m;
        for (int i = 15; i >= 0; i--) begin
            spi_bit(1'b0, m);
            v[i] = m;
        end
    endtask

    task automatic cs_low();
        bus.cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (8) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int          wb, rb, eb;
        logic [15:0] w;
        logic        m;
        bus.sck  = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_we",    32'(bus.we), 32'd0);
        chk("rst_re",    32'(bus.re), 32'd0);
        chk("rst_err",   32'(bus.frame_err), 32'd0);
        chk("rst_miso",  32'(bus.miso), 32'd0);
        chk("rst_row",   32'(bus.row), 32'd0);
        chk("rst_col",   32'(bus.column), 32'd0);
        chk("rst_oe",    32'(bus.data_oe), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Write single
        wb = we_row.size(); eb = err_n;
        cs_low();
        chk("wr1_busy", 32'(bus.busy), 32'd1);
        spi_byte(8'h00); spi_byte(8'h25); spi_wr_word(16'hBEEF);
        cs_high();
        chk("wr1_cnt", 32'(we_row.size() - wb), 32'd1);
        chk("wr1_row", 32'(we_row[wb]), 32'h0004);
        chk("wr1_col", 32'(we_col[wb]), 32'h0020);
        chk("wr1_dat", 32'(we_dat[wb]), 32'hBEEF);
        chk("wr1_err", 32'(err_n - eb), 32'd0);
        chk("wr1_idle_busy", 32'(bus.busy), 32'd0);
        chk("wr1_idle_oe", 32'(bus.data_oe), 32'd0);

        // Read single
        rb = re_row.size();
        cs_low();
        spi_byte(8'h01); spi_byte(8'h25);
        repeat (6) @(negedge clk);
        chk("rd1_re_cnt", 32'(re_row.size() - rb), 32'd1);
        chk("rd1_row", 32'(re_row[rb]), 32'h0004);
        chk("rd1_col", 32'(re_col[rb]), 32'h0020);
        spi_rd_word(w);
        chk("rd1_miso", 32'(w), 32'hBEEF);
        cs_high();
        chk("rd1_re_pref", 32'(re_row.size() - rb), 32'd2);
        chk("rd1_miso_idle", 32'(bus.miso), 32'd0);

        // Write burst wrapping 0xFF -> 0x00
        wb = we_row.size();
        cs_low();
        spi_byte(8'h00); spi_byte(8'hFF); spi_wr_word(16'h1111); spi_wr_word(16'h2222);
        cs_high();
        chk("wrw_cnt", 32'(we_row.size() - wb), 32'd2);
        chk("wrw_row0", 32'(we_row[wb]), 32'h8000);
        chk("wrw_col0", 32'(we_col[wb]), 32'h8000);
        chk("wrw_dat0", 32'(we_dat[wb]), 32'h1111);
        chk("wrw_row1", 32'(we_row[wb+1]), 32'h0001);
        chk("wrw_col1", 32'(we_col[wb+1]), 32'h0001);
        chk("wrw_dat1", 32'(we_dat[wb+1]), 32'h2222);

        // Load 0x10/0x11 then read them back as a burst
        wb = we_row.size();
        cs_low();
        spi_byte(8'h00); spi_byte(8'h10); spi_wr_word(16'hA5A5); spi_wr_word(16'h5A5A);
        cs_high();
        chk("ld_cnt", 32'(we_row.size() - wb), 32'd2);
        rb = re_row.size();
        cs_low();
        spi_byte(8'h01); spi_byte(8'h10);
        spi_rd_word(w);
        chk("rdb_w0", 32'(w), 32'hA5A5);
        spi_rd_word(w);
        chk("rdb_w1", 32'(w), 32'h5A5A);
        cs_high();
        chk("rdb_re_cnt", 32'(re_row.size() - rb), 32'd3);
        chk("rdb_row2", 32'(re_row[rb+2]), 32'h0002);
        chk("rdb_col2", 32'(re_col[rb+2]), 32'h0004);

        // Abort after 9 data bits, then a clean frame
        wb = we_row.size(); eb = err_n;
        cs_low();
        spi_byte(8'h00); spi_byte(8'h30);
        for (int i = 0; i < 9; i++) spi_bit(1'b1, m);
        cs_high();
        chk("abt_err", 32'(err_n - eb), 32'd1);
        chk("abt_we", 32'(we_row.size() - wb), 32'd0);
        chk("abt_busy", 32'(bus.busy), 32'd0);
        wb = we_row.size(); eb = err_n;
        cs_low();
        spi_byte(8'h00); spi_byte(8'h31); spi_wr_word(16'h1234);
        cs_high();
        chk("post_we", 32'(we_row.size() - wb), 32'd1);
        chk("post_dat", 32'(we_dat[wb]), 32'h1234);
        chk("post_row", 32'(we_row[wb]), 32'h0008);
        chk("post_col", 32'(we_col[wb]), 32'h0002);
        chk("post_err", 32'(err_n - eb), 32'd0);

        // Reset in the middle of a read
        eb = err_n;
        cs_low();
        spi_byte(8'h01); spi_byte(8'h25);
        for (int i = 0; i < 5; i++) spi_bit(1'b0, m);
        rst = 1'b0;
        bus.cs_n = 1'b1;
        @(negedge clk);
        chk("rstm_miso", 32'(bus.miso), 32'd0);
        chk("rstm_re", 32'(bus.re), 32'd0);
        chk("rstm_busy", 32'(bus.busy), 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("rstm_err", 32'(err_n - eb), 32'd0);
        cs_low();
        spi_byte(8'h01); spi_byte(8'h25);
        spi_rd_word(w);
        chk("rstm_rd", 32'(w), 32'hBEEF);
        cs_high();

        chk("we_re_overlap", 32'(overlap), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
